// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART TX byte-stream arbiter.
package uart_arb_pkg;

    localparam int BYTE_W  = 8;
    localparam int MAX_REQ = 8;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input int unsigned idx, input int unsigned n);
        logic [MAX_REQ-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i == idx && i < n) v[i] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping modulo N.
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    int cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr_i) + i) % N;
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART TX byte interface among NUM_REQ sources.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_LEN = 64
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [BYTE_W*NUM_REQ-1:0]   req_data_i,
    input  logic [NUM_REQ-1:0]          req_last_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic                        tx_valid_o,
    output logic [BYTE_W-1:0]           tx_data_o,
    input  logic                        tx_ready_i,
    output logic [NUM_REQ-1:0]          grant_o,
    output logic                        busy_o
);

    localparam int IW = $clog2(NUM_REQ);

    state_e            state_q, state_d;
    logic [IW-1:0]     sel_q, sel_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic              beat;
    logic              last_sel;
    logic [MAX_REQ-1:0] sel_oh;

    uart_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output mux depends only on registered state and the owner's inputs, so
    // tx_ready_i never reaches tx_valid_o combinationally.
    always_comb begin
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        req_ready_o = '0;
        if (state_q == LOCKED) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (sel_q == IW'(k)) begin
                    tx_valid_o     = req_valid_i[k];
                    tx_data_o      = req_data_i[k*BYTE_W +: BYTE_W];
                    req_ready_o[k] = tx_ready_i;
                end
            end
        end
    end

    assign sel_oh   = onehot(32'(sel_q), NUM_REQ);
    assign grant_o  = (state_q == LOCKED) ? sel_oh[NUM_REQ-1:0] : '0;
    assign busy_o   = (state_q == LOCKED);
    assign beat     = tx_valid_o & tx_ready_i;
    assign last_sel = req_last_i[sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (beat) begin
                    cnt_d = cnt_q + 8'd1;
                    // Release on the owner's last byte or when this beat fills the grant.
                    if (last_sel || (({1'b0, cnt_q} + 9'd1) == 9'(MAX_LEN))) begin
                        state_d = IDLE;
                        ptr_d   = (sel_q == IW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
